// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter that places the CPU fetch and data ports onto one shared
// memory bus. At most one transfer is in flight; the slave has a one-cycle read latency.
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_byteenable,
  input  logic [31:0]       d_writedata,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [3:0]        m_be_q, m_be_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic i_req, d_req, grant_d, done_i, done_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the port that did not win last time gets the bus.
  assign grant_d = d_req & (~i_req | (last_q == OWN_I));

  assign done_i = (state_q == S_DONE) & (owner_q == OWN_I);
  assign done_d = (state_q == S_DONE) & (owner_q == OWN_D);

  assign i_waitrequest = i_req & ~done_i;
  assign d_waitrequest = d_req & ~done_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          state_d = S_ISSUE;
          owner_d = grant_d;
          if (grant_d) begin
            // A simultaneous read+write is issued as a write.
            m_write_d = d_write;
            m_read_d  = ~d_write;
            m_addr_d  = d_addr[ADDR_W-1:0];
            m_be_d    = d_byteenable;
            m_wdata_d = d_writedata;
          end else begin
            m_write_d = 1'b0;
            m_read_d  = 1'b1;
            m_addr_d  = i_addr[ADDR_W-1:0];
            m_be_d    = 4'b1111;
            m_wdata_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (!m_waitrequest) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = m_write_q ? S_DONE : S_RDATA;
        end
      end
      S_RDATA: begin
        if (owner_q == OWN_D) d_rdata_d = m_readdata;
        else                  i_rdata_d = m_readdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_be_q    <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_addr       = m_addr_q;
  assign m_byteenable = m_be_q;
  assign m_writedata  = m_wdata_q;
  assign i_readdata   = i_rdata_q;
  assign d_readdata   = d_rdata_q;

  // Address bits above ADDR_W are dropped by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed scenarios plus random two-port traffic
// against a byte-memory reference and a round-robin ordering rule.
module tb_mips_cpu_bus_arbiter;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read, d_read, d_write;
  logic [31:0]       i_addr, d_addr, d_writedata;
  logic [3:0]        d_byteenable;
  logic              i_waitrequest, d_waitrequest;
  logic [31:0]       i_readdata, d_readdata;
  logic              m_read, m_write, m_waitrequest;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata, m_readdata;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_byteenable(d_byteenable),
    .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_byteenable(m_byteenable),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata)
  );

  // Bus memory slave: 256 bytes, little-endian, one-cycle registered read.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else begin
      if (m_read && !m_waitrequest)
        m_readdata <= {mem[8'(m_addr[7:0] + 3)], mem[8'(m_addr[7:0] + 2)],
                       mem[8'(m_addr[7:0] + 1)], mem[m_addr[7:0]]};
      if (m_write && !m_waitrequest)
        for (int k = 0; k < 4; k++)
          if (m_byteenable[k]) mem[8'(m_addr[7:0] + k)] <= m_writedata[8*k +: 8];
    end
  end

  logic [7:0] ref_mem [0:255];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[8'(b + 3)], ref_mem[8'(b + 2)], ref_mem[8'(b + 1)], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int k = 0; k < 4; k++) if (be[k]) ref_mem[8'(a[7:0] + k)] = d[8*k +: 8];
  endtask

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_req();
    i_read = 0; d_read = 0; d_write = 0; i_addr = 0; d_addr = 0;
    d_byteenable = 0; d_writedata = 0;
  endtask

  task automatic do_reset();
    reset = 1; ref_init();
    step(); step();
    reset = 0;
  endtask

  // One isolated transfer from an idle arbiter; checks bus fields, latency and data.
  task automatic xfer(input bit port_d, input bit wr, input bit both, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input int stall);
    int done, lat;
    logic [15:0] a16;
    logic [31:0] exp_rd;
    a16 = addr[15:0];
    exp_rd = ref_word(a16);
    if (port_d) begin
      d_read = both | ~wr; d_write = wr; d_addr = addr; d_byteenable = be; d_writedata = wd;
    end else begin
      i_read = 1; i_addr = addr;
    end
    lat = (wr ? 2 : 3) + stall;
    done = -1;
    for (int k = 0; k <= lat + 20; k++) begin
      m_waitrequest = (stall > 0) && (k <= stall);
      @(negedge clk);
      if (k >= 1 && k <= stall + 1) begin
        check("issue_read", m_read, !wr);
        check("issue_write", m_write, wr);
        check("issue_addr", m_addr, a16);
        check("issue_be", m_byteenable, port_d ? be : 4'hF);
        if (wr) check("issue_wdata", m_writedata, wd);
      end
      if (!(port_d ? d_waitrequest : i_waitrequest)) begin
        done = k;
        if (!wr) check("rdata", port_d ? d_readdata : i_readdata, exp_rd);
        break;
      end
      step();
    end
    check("latency", done, lat);
    if (wr) ref_write(a16, be, wd);
    step();
    clear_req();
    m_waitrequest = 0;
  endtask

  // random-phase state
  int cyc, acc_cyc, exp_next, iwait, dwait;
  bit acc_valid, acc_wr, dwr, i_done, d_done, timed_out;
  logic [15:0] acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wd;

  task automatic complete(input bit p, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] rd, input bit other_pending);
    if (exp_next >= 0) check("rr_order", p, exp_next[0]);
    check("rnd_accepted", acc_valid, 1'b1);
    check("rnd_latency", cyc - acc_cyc, wr ? 1 : 2);
    check("rnd_kind", acc_wr, wr);
    check("rnd_addr", acc_addr, addr[15:0]);
    check("rnd_be", acc_be, p ? be : 4'hF);
    if (wr) begin
      check("rnd_wdata", acc_wd, wd);
      ref_write(addr[15:0], be, wd);
    end else begin
      check("rnd_rdata", rd, ref_word(addr[15:0]));
    end
    acc_valid = 0;
    exp_next = other_pending ? int'(!p) : -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq_k[$];
    bit seq_p[$];
    int r;
    clear_req();
    m_waitrequest = 0;
    reset = 1;
    ref_init();
    repeat (2) @(posedge clk);
    #1 i_read = 1;
    @(negedge clk);
    check("rst_m_read", m_read, 0);
    check("rst_m_write", m_write, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_be", m_byteenable, 0);
    check("rst_m_wdata", m_writedata, 0);
    check("rst_i_rdata", i_readdata, 0);
    check("rst_d_rdata", d_readdata, 0);
    check("rst_i_wait", i_waitrequest, 1);
    check("rst_d_wait", d_waitrequest, 0);
    step();
    i_read = 0;
    reset = 0;

    // store 11 22 33 44 at 0x10, fetch it back through upper-bit-laden address
    xfer(1, 1, 0, 32'h0000_0010, 4'hF, 32'h4433_2211, 0);
    xfer(0, 0, 0, 32'hFFFF_0010, 4'hF, 32'h0, 0);
    check("fetch_const", i_readdata, 32'h4433_2211);
    xfer(1, 1, 0, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 0);
    xfer(1, 0, 0, 32'h0000_0020, 4'hF, 32'h0, 0);
    check("load_const", d_readdata, 32'hDEAD_BEEF);
    check("i_rdata_kept", i_readdata, 32'h4433_2211);
    xfer(0, 0, 0, 32'h0000_0020, 4'hF, 32'h0, 3);
    xfer(1, 1, 0, 32'h0000_0041, 4'h6, 32'h1234_5678, 2);
    xfer(1, 1, 1, 32'h0000_0030, 4'b0001, 32'h0000_00AB, 0);
    xfer(1, 0, 0, 32'h0000_0030, 4'hF, 32'h0, 0);
    check("both_byte", d_readdata[7:0], 8'hAB);

    // contention right after reset: D, I, D, I
    do_reset();
    i_read = 1; i_addr = 32'h0000_0010;
    d_read = 1; d_addr = 32'h0000_0020; d_byteenable = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!d_waitrequest) begin
        seq_k.push_back(k); seq_p.push_back(1);
        check("cont_d_rdata", d_readdata, ref_word(16'h0020));
      end
      if (!i_waitrequest) begin
        seq_k.push_back(k); seq_p.push_back(0);
        check("cont_i_rdata", i_readdata, ref_word(16'h0010));
      end
      step();
    end
    clear_req();
    check("cont_count", seq_k.size(), 4);
    for (int j = 0; j < 4 && j < seq_k.size(); j++) begin
      check("cont_cycle", seq_k[j], 3 + 4 * j);
      check("cont_port", seq_p[j], (j % 2 == 0));
    end
    step();

    // reset during a stalled ISSUE: strobe drops immediately, no completion
    i_read = 1; i_addr = 32'h0000_0040; m_waitrequest = 1;
    step();
    @(negedge clk);
    check("pre_rst_m_read", m_read, 1);
    #1 reset = 1; ref_init();
    #1 check("rst_async_m_read", m_read, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("rst_no_done_i", i_waitrequest, 1);
    end
    step();
    clear_req(); reset = 0; m_waitrequest = 0;
    xfer(0, 0, 0, 32'h0000_0040, 4'hF, 32'h0, 0);

    // reset in RDATA
    i_read = 1; i_addr = 32'h0000_0044;
    step(); step();
    reset = 1; ref_init();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rdata_rst_m_read", m_read, 0);
      check("rdata_rst_i_wait", i_waitrequest, 1);
      step();
    end
    clear_req(); reset = 0;
    xfer(0, 0, 0, 32'h0000_0044, 4'hF, 32'h0, 0);

    // random two-port traffic
    acc_valid = 0; exp_next = -1; iwait = 0; dwait = 0; timed_out = 0; dwr = 0;
    for (cyc = 0; cyc < 4000 && !timed_out; cyc++) begin
      @(negedge clk);
      if (m_read && m_write) check("strobe_excl", 1, 0);
      if ((m_read || m_write) && !m_waitrequest) begin
        acc_valid = 1; acc_cyc = cyc; acc_wr = m_write;
        acc_addr = m_addr; acc_be = m_byteenable; acc_wd = m_writedata;
      end
      i_done = 0; d_done = 0;
      if (i_read && !i_waitrequest) begin
        i_done = 1;
        complete(0, 0, i_addr, 4'hF, 32'h0, i_readdata, d_read | d_write);
      end
      if ((d_read || d_write) && !d_waitrequest) begin
        d_done = 1;
        complete(1, dwr, d_addr, d_byteenable, d_writedata, d_readdata, i_read);
      end
      if (i_read && !i_done) iwait++;
      if ((d_read || d_write) && !d_done) dwait++;
      if (iwait > 100 || dwait > 100) begin
        check("rnd_timeout", iwait > 100 || dwait > 100, 0);
        timed_out = 1;
      end
      step();
      m_waitrequest = ($urandom_range(0, 3) == 0);
      if (i_done) i_read = 0;
      if (d_done) begin d_read = 0; d_write = 0; end
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read = 1; iwait = 0;
        i_addr = {16'($urandom), 8'h00, 8'($urandom)};
      end
      if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 2);
        d_read = (r != 1); d_write = (r != 0); dwr = (r != 0); dwait = 0;
        d_addr = {16'($urandom), 8'h00, 8'($urandom)};
        d_byteenable = 4'($urandom);
        d_writedata = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Two-port arbiter placing the CPU instruction-fetch port and data (load/store) port onto the single shared memory bus, whose slave accepts one transfer at a time with a fixed one-cycle registered read latency. Each requester sees an Avalon-style slave with `waitrequest` back-pressure. The arbiter grants round-robin, issues one downstream transfer, captures read data and completes the owning requester. It sits between the CPU core and the bus memory.

## Interface
- `ADDR_W`, 16: downstream address width; requester addresses are truncated to the low `ADDR_W` bits.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  instruction fetch request, held until `i_waitrequest` low.
- `i_addr`  in  32  fetch byte address.
- `i_waitrequest`  out  1  high while a fetch is pending and not completing.
- `i_readdata`  out  32  fetch data, valid in the completion cycle.
- `d_read`, `d_write`  in  1 each  data requests, held until `d_waitrequest` low.
- `d_addr`  in  32  data byte address.
- `d_byteenable`  in  4  lane enables.
- `d_writedata`  in  32  store data.
- `d_waitrequest`  out  1  as `i_waitrequest`, for the data port.
- `d_readdata`  out  32  load data, valid in the completion cycle.
- `m_read`, `m_write`  out  1 each  downstream strobes, never both high.
- `m_addr`  out  ADDR_W  downstream address.
- `m_byteenable`  out  4  downstream enables; `4'b1111` for fetches.
- `m_writedata`  out  32  downstream store data.
- `m_waitrequest`  in  1  downstream stall.
- `m_readdata`  in  32  downstream data, valid the cycle after read acceptance.

## Operation
- States: IDLE, ISSUE, RDATA, DONE; `owner` register (I/D) and `last` register (last granted port).
- IDLE: no pending request → stay. One pending → grant it. Both pending → grant the port ≠ `last`. Grant latches owner and registers `m_*` from the owner's inputs → ISSUE.
- ISSUE: `m_read`/`m_write` high. Accepted at an edge with `m_waitrequest`=0 → RDATA (read) or DONE (write). While `m_waitrequest`=1 hold all `m_*` stable.
- RDATA: strobes low; capture `m_readdata` into owner's readdata register → DONE.
- DONE: owner's `*_waitrequest`=0 for exactly this cycle; `last`←owner → IDLE.
- `*_waitrequest` = request & ~(state==DONE & owner==port); combinational. Idle ports (no request) see 0.
- `d_read` and `d_write` both high: treated as write.
- Request inputs are sampled only at grant; changes while the transfer is in flight are ignored.
- Non-owner readdata register keeps its previous value.
- No back-to-back overlap: at most one downstream transfer outstanding.

## Timing
- Reset (async, immediate): state=IDLE, `last`=I (data wins the first tie), `m_read`=`m_write`=0, `m_addr`=0, `m_byteenable`=0, `m_writedata`=0, `i_readdata`=`d_readdata`=0; waitrequests follow the formula (high for any asserted request).
- Reset mid-transfer: strobes drop in the same cycle, transfer abandoned, no completion issued; requester must re-present after reset.
- Read, zero stall: request at cycle 0 → ISSUE cycle 1 → RDATA cycle 2 → DONE cycle 3 (data valid, waitrequest low); request may drop at edge 4. Each downstream stall cycle adds one.
- Write, zero stall: DONE in cycle 2; complete at edge 3.
- Next grant earliest in the IDLE cycle after DONE; sustained zero-stall throughput one read per 4 cycles, one write per 3.
- Downstream address = `addr[ADDR_W-1:0]`; no alignment checking.

## Test plan
- Fetch alone: `i_read`=1, `i_addr`=0x0000_0010, memory 0x10..0x13 = 11 22 33 44 → `m_read` cycle 1, `m_addr`=0x0010, `m_byteenable`=1111, `i_readdata`=0x4433_2211 with `i_waitrequest`=0 in cycle 3 only.
- Store then load: `d_write`, addr 0x20, be 1111, data 0xDEADBEEF → DONE cycle 2; then `d_read` 0x20 → `d_readdata`=0xDEADBEEF in cycle 3 of that transfer.
- Simultaneous requests after reset: `i_read` and `d_read` both at cycle 0 → data granted first, fetch granted in cycle 4, completes cycle 7; repeated contention alternates D, I, D, I.
- Downstream stall: `m_waitrequest`=1 for 3 cycles during ISSUE → `m_addr`/`m_read` stable throughout, completion delayed by exactly 3 cycles.
- Reset asserted in RDATA → `m_read`=0, no `*_waitrequest` low pulse, state IDLE; fresh `i_read` after release completes normally in 4 cycles.
- `d_read`=`d_write`=1, be 0001, data 0x0000_00AB, addr 0x30 → only `m_write` asserted, byte 0x30 becomes 0xAB.
